// File: rtl/csr_pkg.sv
// csr_pkg: shared Zicsr encodings, sequencer states and request-classification helpers
package csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam int CSR_RW_RD = 1;
    localparam int CSR_RW_WR = 0;

    localparam logic [1:0] CSR_RO_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        RESP = 2'b11
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

    function automatic logic read_needed(input logic [2:0] f3, input logic rd_zero);
        return !(f3[1:0] == CSR_RW[1:0] && rd_zero);
    endfunction

    function automatic logic write_needed(input logic [2:0] f3, input logic rs1_zero);
        return f3[1:0] == CSR_RW[1:0] || !rs1_zero;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: new CSR value from old value, operand and Zicsr funct3 (RW / RS / RC)
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] wval
);

    // funct3[2] only selects the operand source upstream; the low bits pick the operation
    always_comb begin
        wval = funct3[1:0] == CSR_RW[1:0] ? operand :
               funct3[1:0] == CSR_RS[1:0] ? (old | operand) :
                                            (old & ~operand);
    end

endmodule

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer: issues Zicsr read/write cycles to the CSR group; CSR_RO_CHECK_EN traps writes to read-only space
module csr_access_sequencer
    import csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_zimm,
    input  logic              req_rd_zero,
    input  logic              req_rs1_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [1:0]        csr_rw,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata
);

    state_t            state, state_nx;
    logic [2:0]        f3_q;
    logic [CSR_AW-1:0] addr_q;
    logic [XLEN-1:0]   operand_q;
    logic              rd_zero_q, rs1_zero_q;
    logic              req_rd, req_illegal, accept;
    logic [XLEN-1:0]   req_operand, old, wval;

    assign accept      = req_valid && state == IDLE;
    assign req_rd      = read_needed(req_funct3, req_rd_zero);
    assign req_operand = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_data;
`ifdef CSR_RO_CHECK_EN
    assign req_illegal = !f3_legal(req_funct3) ||
                         (write_needed(req_funct3, req_rs1_zero) &&
                          req_addr[CSR_AW-1:CSR_AW-2] == CSR_RO_SPACE);
`else
    assign req_illegal = !f3_legal(req_funct3);
`endif

    assign old = read_needed(f3_q, rd_zero_q) ? csr_rdata : '0;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (f3_q),
        .old     (old),
        .operand (operand_q),
        .wval    (wval)
    );

    // state register; reset drops any in-flight CSR cycle at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: illegal skips straight to RESP, reads go through READ first
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_illegal ? RESP : req_rd ? READ : EXEC;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = RESP;
            default: if (resp_ready) state_nx = IDLE;
        endcase
    end

    // port decode from registered state and latched fields only
    always_comb begin
        req_ready            = state == IDLE;
        resp_valid           = state == RESP;
        csr_rw               = 2'b00;
        csr_rw[CSR_RW_RD]    = state == READ;
        csr_rw[CSR_RW_WR]    = state == EXEC && write_needed(f3_q, rs1_zero_q);
        csr_addr             = (state == READ || state == EXEC) ? addr_q : '0;
        csr_wdata            = state == EXEC ? wval : '0;
    end

    // request latch on accept; response captured on accept (illegal) or in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q         <= '0;
            addr_q       <= '0;
            operand_q    <= '0;
            rd_zero_q    <= 1'b0;
            rs1_zero_q   <= 1'b0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else if (accept) begin
            f3_q         <= req_funct3;
            addr_q       <= req_addr;
            operand_q    <= req_operand;
            rd_zero_q    <= req_rd_zero;
            rs1_zero_q   <= req_rs1_zero;
            resp_rdata   <= '0;
            resp_illegal <= req_illegal;
        end else if (state == EXEC) begin
            resp_rdata   <= old;
            resp_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb_csr_access_sequencer: random and directed Zicsr requests against a transaction-level reference model
module tb_csr_access_sequencer;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [63:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic        req_rd_zero, req_rs1_zero;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_illegal;
    logic [11:0] csr_addr;
    logic [1:0]  csr_rw;
    logic [63:0] csr_wdata, csr_rdata;

    logic [63:0] mem [0:4095];
    logic [63:0] ref_mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [63:0] pre_data;
    logic [11:0] addrs [8];
    int          total, passed;

    csr_access_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_data (req_rs1_data),
        .req_zimm     (req_zimm),
        .req_rd_zero  (req_rd_zero),
        .req_rs1_zero (req_rs1_zero),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .csr_addr     (csr_addr),
        .csr_rw       (csr_rw),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR register group: registered read on posedge, write on negedge
    always @(posedge clk) if (csr_rw[1]) csr_rdata <= mem[csr_addr];
    always @(negedge clk) begin
        if (pre_we)         mem[pre_addr] <= pre_data;
        else if (csr_rw[0]) mem[csr_addr] <= csr_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk); #1;
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic scramble();
        req_funct3   = 3'($urandom);
        req_addr     = 12'($urandom);
        req_rs1_data = {$urandom, $urandom};
        req_zimm     = 5'($urandom);
        req_rd_zero  = 1'($urandom);
        req_rs1_zero = 1'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                          input logic [4:0] z, input logic rdz, input logic rs1z, input int hold);
        logic [1:0]  t;
        logic [63:0] opnd, old, nv, wseen;
        logic        rdn, wrn, ill;
        int          lat, nr, nw, cyc;
        t    = f3[1:0];
        opnd = f3[2] ? {59'b0, z} : rs1;
        rdn  = !(t == 2'd1 && rdz);
        wrn  = (t == 2'd1) || !rs1z;
        ill  = (t == 2'd0);
`ifdef CSR_RO_CHECK_EN
        if (wrn && a[11:10] == 2'b11) ill = 1'b1;
`endif
        old  = (!ill && rdn) ? ref_mem[a] : 64'd0;
        nv   = t == 2'd1 ? opnd : t == 2'd2 ? (old | opnd) : (old & ~opnd);
        lat  = ill ? 1 : rdn ? 3 : 2;
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_funct3 = f3; req_addr = a; req_rs1_data = rs1; req_zimm = z;
        req_rd_zero = rdz; req_rs1_zero = rs1z; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        cyc = 1; nr = 0; nw = 0; wseen = 64'd0;
        while (!resp_valid && cyc < 8) begin
            if (csr_rw == 2'b10) begin nr++; check("rd_addr", {52'd0, csr_addr}, {52'd0, a}); end
            if (csr_rw == 2'b01) begin nw++; wseen = csr_wdata; check("wr_addr", {52'd0, csr_addr}, {52'd0, a}); end
            if (csr_rw == 2'b11) check("rw_both", {62'd0, csr_rw}, 64'd0);
            check("req_ready_busy", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("reads", 64'(nr), (ill || !rdn) ? 64'd0 : 64'd1);
        check("writes", 64'(nw), (ill || !wrn) ? 64'd0 : 64'd1);
        if (!ill && wrn) check("wdata", wseen, nv);
        check("rdata", resp_rdata, old);
        check("illegal", {63'd0, resp_illegal}, {63'd0, ill});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, old);
            check("hold_illegal", {63'd0, resp_illegal}, {63'd0, ill});
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            check("hold_rw", {62'd0, csr_rw}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", {63'd0, resp_valid}, 64'd0);
        check("req_ready_back", {63'd0, req_ready}, 64'd1);
        if (!ill && wrn) ref_mem[a] = nv;
        check("mem", mem[a], ref_mem[a]);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [11:0] a;
        logic [63:0] rs1;
        logic [4:0]  z;
        logic        rdz, rs1z;
        total = 0; passed = 0;
        addrs = '{12'h300, 12'h341, 12'h305, 12'hC00, 12'h7C0, 12'hF14, 12'h340, 12'h001};
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0;
        scramble();
        for (int i = 0; i < 8; i++) preload(addrs[i], {$urandom, $urandom});
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_rw", {62'd0, csr_rw}, 64'd0);
        check("rst_addr", {52'd0, csr_addr}, 64'd0);
        check("rst_wdata", csr_wdata, 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_illegal", {63'd0, resp_illegal}, 64'd0);

        preload(12'h300, 64'h8);
        run_op(3'b010, 12'h300, 64'h80, 5'd0, 1'b0, 1'b0, 0);
        check("rs_result", mem[12'h300], 64'h88);
        run_op(3'b001, 12'h341, 64'hDEAD, 5'd0, 1'b1, 1'b0, 0);
        check("rw_result", mem[12'h341], 64'hDEAD);
        preload(12'h340, 64'hFF);
        run_op(3'b111, 12'h340, 64'd0, 5'd0, 1'b0, 1'b1, 0);
        check("rci_unchanged", mem[12'h340], 64'hFF);
        run_op(3'b100, 12'h300, 64'h5, 5'd3, 1'b0, 1'b0, 0);
        run_op(3'b000, 12'h341, 64'h5, 5'd3, 1'b0, 1'b0, 1);
        run_op(3'b011, 12'h305, {$urandom, $urandom}, 5'd0, 1'b0, 1'b0, 5);
        run_op(3'b001, 12'hC00, 64'h1234, 5'd0, 1'b0, 1'b0, 0);
        run_op(3'b010, 12'hC00, 64'h0, 5'd0, 1'b0, 1'b1, 0);

        preload(12'h305, 64'h5555);
        req_funct3 = 3'b001; req_addr = 12'h305; req_rs1_data = 64'h1234;
        req_zimm = 5'd0; req_rd_zero = 1'b1; req_rs1_zero = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_exec_rw", {62'd0, csr_rw}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rw", {62'd0, csr_rw}, 64'd0);
        check("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
        check("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_rdata", resp_rdata, 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_mem", mem[12'h305], 64'h5555);
        check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        for (int n = 0; n < 60; n++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = addrs[$urandom_range(0, 7)];
            rdz  = 1'($urandom_range(0, 1));
            rs1z = 1'($urandom_range(0, 1));
            rs1  = (f3[2] || rs1z) ? 64'd0 : {$urandom, $urandom};
            z    = (!f3[2] || rs1z) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(f3, a, rs1, z, rdz, rs1z, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
